// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, services control-unit fetch strobes
// with a req/ack read of instruction memory and applies control-driven PC loads.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        r_l,
   input  logic        fetch_req,
   input  logic        pc_write,
   input  logic [1:0]  pc_source,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_out,
   input  logic [25:0] jump_target,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] pc_output,
   output logic [31:0] pc_plus4,
   output logic [31:0] ir_out,
   output logic        fetch_busy,
   output logic        fetch_done,
   output logic        fetch_err
);

   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   logic [1:0]       r_state;
   logic [31:0]      r_pc;
   logic [31:0]      r_ir;
   logic [31:0]      r_mem_addr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mem_rd;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic [1:0]       w_state_nxt;
   logic [31:0]      w_pc_nxt;
   logic [31:0]      w_ir_nxt;
   logic [31:0]      w_addr_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [31:0]      w_sel_pc;
   logic [31:0]      w_pc_req;

   // PC load source; reserved encoding keeps the current PC
   always_comb begin
      w_sel_pc = r_pc;
      case (pc_source)
         2'b00:   w_sel_pc = alu_result;
         2'b01:   w_sel_pc = alu_out;
         2'b10:   w_sel_pc = {r_pc[31:28], jump_target, 2'b00};
         default: w_sel_pc = r_pc;
      endcase
   end

   // A same-cycle pc_write takes effect before the fetch address is chosen
   assign w_pc_req = pc_write ? w_sel_pc : r_pc;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_addr_nxt  = r_mem_addr;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_REQ: begin
            // PC loads and new fetch strobes are dropped while a read is outstanding
            if (mem_ack) begin
               w_ir_nxt    = mem_rdata;
               w_pc_nxt    = r_pc + 32'd4;
               w_state_nxt = S_DONE;
            end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
               w_state_nxt = S_ERR;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_pc_nxt = w_pc_req;
            if (fetch_req) begin
               if (w_pc_req[1:0] == 2'b00) begin
                  w_state_nxt = S_REQ;
                  w_addr_nxt  = w_pc_req;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = S_ERR;
               end
            end else if (r_state == S_DONE) begin
               w_state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // Status outputs are registered from the next state so they align with r_state
   always_ff @(posedge clock or negedge r_l) begin
      if (!r_l) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_ir       <= '0;
         r_mem_addr <= '0;
         r_cnt      <= '0;
         r_mem_rd   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_ir       <= w_ir_nxt;
         r_mem_addr <= w_addr_nxt;
         r_cnt      <= w_cnt_nxt;
         r_mem_rd   <= (w_state_nxt == S_REQ);
         r_busy     <= (w_state_nxt == S_REQ);
         r_done     <= (w_state_nxt == S_DONE);
         r_err      <= (w_state_nxt == S_ERR);
      end
   end

   assign mem_addr   = r_mem_addr;
   assign mem_rd     = r_mem_rd;
   assign pc_output  = r_pc;
   assign pc_plus4   = r_pc + 32'd4;
   assign ir_out     = r_ir;
   assign fetch_busy = r_busy;
   assign fetch_done = r_done;
   assign fetch_err  = r_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-computed expectations for fetch,
// wait states, timeout, PC loads, alignment error, PC wrap and async reset.
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   logic        r_l;
   logic        fetch_req;
   logic        pc_write;
   logic [1:0]  pc_source;
   logic [31:0] alu_result;
   logic [31:0] alu_out;
   logic [25:0] jump_target;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] pc_output;
   logic [31:0] pc_plus4;
   logic [31:0] ir_out;
   logic        fetch_busy;
   logic        fetch_done;
   logic        fetch_err;

   int n_vec = 0;
   int n_err = 0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(15)) dut (
      .clock       (clock),
      .r_l         (r_l),
      .fetch_req   (fetch_req),
      .pc_write    (pc_write),
      .pc_source   (pc_source),
      .alu_result  (alu_result),
      .alu_out     (alu_out),
      .jump_target (jump_target),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .pc_output   (pc_output),
      .pc_plus4    (pc_plus4),
      .ir_out      (ir_out),
      .fetch_busy  (fetch_busy),
      .fetch_done  (fetch_done),
      .fetch_err   (fetch_err)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int cnt;
      r_l = 1'b0; fetch_req = 1'b0; pc_write = 1'b0; pc_source = 2'b00;
      alu_result = '0; alu_out = '0; jump_target = '0; mem_ack = 1'b0; mem_rdata = '0;

      #12;
      check_eq("rst_pc",    pc_output, 32'h0);
      check_eq("rst_ir",    ir_out, 32'h0);
      check_eq("rst_addr",  mem_addr, 32'h0);
      check_eq("rst_rd",    32'(mem_rd), 32'h0);
      check_eq("rst_flags", {29'h0, fetch_busy, fetch_done, fetch_err}, 32'h0);
      check_eq("rst_pc4",   pc_plus4, 32'h4);
      r_l = 1'b1;
      tick();

      // Fetch at PC 0, ack on first REQ cycle
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      check_eq("f1_rd",   32'(mem_rd), 32'h1);
      check_eq("f1_addr", mem_addr, 32'h0);
      check_eq("f1_busy", 32'(fetch_busy), 32'h1);
      mem_ack = 1'b1; mem_rdata = 32'h8C22_0004;
      tick();
      mem_ack = 1'b0;
      check_eq("f1_done", 32'(fetch_done), 32'h1);
      check_eq("f1_ir",   ir_out, 32'h8C22_0004);
      check_eq("f1_pc",   pc_output, 32'h4);
      check_eq("f1_rd0",  32'(mem_rd), 32'h0);
      tick();
      check_eq("f1_done0", 32'(fetch_done), 32'h0);

      // Stray ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0;
      check_eq("stray_ir", ir_out, 32'h8C22_0004);
      check_eq("stray_pc", pc_output, 32'h4);

      // Ack after three wait cycles
      fetch_req = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      fetch_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("w_rd",   32'(mem_rd), 32'h1);
         check_eq("w_addr", mem_addr, 32'h4);
         check_eq("w_pc",   pc_output, 32'h4);
         check_eq("w_done", 32'(fetch_done), 32'h0);
         tick();
      end
      check_eq("w_rd4", 32'(mem_rd), 32'h1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check_eq("w_done1", 32'(fetch_done), 32'h1);
      check_eq("w_ir",    ir_out, 32'h1234_5678);
      check_eq("w_pc8",   pc_output, 32'h8);
      tick();
      check_eq("w_done0", 32'(fetch_done), 32'h0);
      check_eq("w_pc8b",  pc_output, 32'h8);

      // No ack: timeout after 15 REQ cycles
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      cnt = 0;
      while (mem_rd && cnt < 40) begin
         cnt++;
         tick();
      end
      check_eq("to_cycles", 32'(cnt), 32'd15);
      check_eq("to_err",    32'(fetch_err), 32'h1);
      check_eq("to_rd",     32'(mem_rd), 32'h0);
      check_eq("to_pc",     pc_output, 32'h8);
      check_eq("to_ir",     ir_out, 32'h1234_5678);
      tick();
      check_eq("to_err_held", 32'(fetch_err), 32'h1);

      // Retry from ERR; pc_write during REQ must not touch PC
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      check_eq("rt_err0", 32'(fetch_err), 32'h0);
      check_eq("rt_addr", mem_addr, 32'h8);
      pc_write = 1'b1; pc_source = 2'b00; alu_result = 32'h0000_0100;
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
      tick();
      pc_write = 1'b0; mem_ack = 1'b0;
      check_eq("rt_done", 32'(fetch_done), 32'h1);
      check_eq("rt_err",  32'(fetch_err), 32'h0);
      check_eq("rt_pc",   pc_output, 32'hC);
      check_eq("rt_ir",   ir_out, 32'hCAFE_0001);
      tick();

      // PC loads from each source, then jump with same-cycle fetch
      pc_write = 1'b1; pc_source = 2'b01; alu_out = 32'h2000_0010;
      tick();
      check_eq("ld_aluout", pc_output, 32'h2000_0010);
      pc_source = 2'b11; alu_result = 32'h5555_5554;
      tick();
      check_eq("ld_rsvd", pc_output, 32'h2000_0010);
      pc_source = 2'b00; alu_result = 32'h4000_0000;
      tick();
      check_eq("ld_alures", pc_output, 32'h4000_0000);
      pc_source = 2'b10; jump_target = 26'h000_0010; fetch_req = 1'b1;
      tick();
      pc_write = 1'b0; fetch_req = 1'b0;
      check_eq("j_pc",   pc_output, 32'h4000_0040);
      check_eq("j_addr", mem_addr, 32'h4000_0040);
      check_eq("j_rd",   32'(mem_rd), 32'h1);
      mem_ack = 1'b1; mem_rdata = 32'h0800_0000;
      tick();
      mem_ack = 1'b0;
      check_eq("j_pc4", pc_output, 32'h4000_0044);
      tick();

      // Misaligned PC: straight to ERR, no memory request
      pc_write = 1'b1; pc_source = 2'b00; alu_result = 32'h0000_0006;
      tick();
      pc_write = 1'b0;
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      check_eq("mis_err",  32'(fetch_err), 32'h1);
      check_eq("mis_rd",   32'(mem_rd), 32'h0);
      check_eq("mis_busy", 32'(fetch_busy), 32'h0);
      tick();
      check_eq("mis_rd2", 32'(mem_rd), 32'h0);
      check_eq("mis_pc",  pc_output, 32'h6);

      // Redirect out of ERR to top word, fetch wraps PC to 0
      pc_write = 1'b1; alu_result = 32'hFFFF_FFFC; fetch_req = 1'b1;
      tick();
      pc_write = 1'b0; fetch_req = 1'b0;
      check_eq("wr_addr", mem_addr, 32'hFFFF_FFFC);
      check_eq("wr_pc4",  pc_plus4, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h0000_0021;
      tick();
      mem_ack = 1'b0;
      check_eq("wr_pc",   pc_output, 32'h0);
      check_eq("wr_done", 32'(fetch_done), 32'h1);
      check_eq("wr_err",  32'(fetch_err), 32'h0);
      tick();

      // Async reset in the middle of a read
      pc_write = 1'b1; alu_result = 32'h0000_0080; fetch_req = 1'b1;
      tick();
      pc_write = 1'b0; fetch_req = 1'b0;
      check_eq("ar_rd1", 32'(mem_rd), 32'h1);
      #2 r_l = 1'b0;
      #1;
      check_eq("ar_rd",   32'(mem_rd), 32'h0);
      check_eq("ar_pc",   pc_output, 32'h0);
      check_eq("ar_ir",   ir_out, 32'h0);
      check_eq("ar_busy", 32'(fetch_busy), 32'h0);
      check_eq("ar_addr", mem_addr, 32'h0);
      r_l = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
      tick();
      mem_ack = 1'b0;
      check_eq("ar_ack_ir", ir_out, 32'h0);
      check_eq("ar_ack_pc", pc_output, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
